// File: rtl/boot_seq_pkg.sv
// Shared definitions for the post-reset boot sequencer.
// Contents: FSM state encoding, PSRAM init opcodes, command table lookup,
// and a small constant-max helper used for counter sizing.
package boot_seq_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_MRST,
        ST_CMD,
        ST_WAIT,
        ST_GAP,
        ST_RETRY,
        ST_STAGE,
        ST_DONE
    } state_t;

    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;
    localparam logic [7:0] CMD_QPI   = 8'h35;

    localparam int unsigned SEQ_LEN = 3;
    localparam int unsigned IDX_W   = 2;

    // Command table SEQ[0..2]; out-of-range indices fall back to the last entry.
    function automatic logic [7:0] seq_code(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    seq_code = CMD_RSTEN;
            2'd1:    seq_code = CMD_RST;
            default: seq_code = CMD_QPI;
        endcase
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        umax = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/boot_seq.sv
// Post-reset boot sequencer: waits for PSRAM power-up, releases the memory
// controller reset, issues the PSRAM init commands with timeout/retry, then
// releases the staged resets one by one and flags done or error.
// Ports:
//   clk, rst          - clk_1x clock, synchronous active-high system reset
//   mem_rst           - memory controller reset (active-high)
//   mem_cmd_valid/ready/code/done - command port to the memory controller
//   rst_stage         - per-stage resets, bit 0 released first
//   boot_done         - sticky success flag
//   boot_err          - sticky failure flag (retries exhausted)
module boot_seq
    import boot_seq_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES  = 3800,
    parameter int unsigned MEMRST_CYCLES = 8,
    parameter int unsigned CMD_GAP       = 4,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned MAX_RETRY     = 2,
    parameter int unsigned N_STAGES      = 3,
    parameter int unsigned STAGE_GAP     = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_rst,
    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic [7:0]          mem_cmd_code,
    input  logic                mem_cmd_done,
    output logic [N_STAGES-1:0] rst_stage,
    output logic                boot_done,
    output logic                boot_err
);

    // Counter covers every interval it times, so it can never wrap.
    localparam int unsigned CNT_MAX = umax(umax(PWRUP_CYCLES, TIMEOUT),
                                           umax(umax(MEMRST_CYCLES, CMD_GAP), STAGE_GAP));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [RTY_W-1:0]      retry, retry_nxt;
    logic                  mem_rst_nxt, valid_nxt, done_nxt, err_nxt;
    logic [7:0]            code_nxt;
    logic [N_STAGES-1:0]   stage_nxt;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_PWRUP;
            cnt           <= '0;
            idx           <= '0;
            retry         <= '0;
            mem_rst       <= 1'b1;
            mem_cmd_valid <= 1'b0;
            mem_cmd_code  <= 8'h00;
            rst_stage     <= '1;
            boot_done     <= 1'b0;
            boot_err      <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            retry         <= retry_nxt;
            mem_rst       <= mem_rst_nxt;
            mem_cmd_valid <= valid_nxt;
            mem_cmd_code  <= code_nxt;
            rst_stage     <= stage_nxt;
            boot_done     <= done_nxt;
            boot_err      <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        retry_nxt   = retry;
        mem_rst_nxt = mem_rst;
        valid_nxt   = mem_cmd_valid;
        code_nxt    = mem_cmd_code;
        stage_nxt   = rst_stage;
        done_nxt    = boot_done;
        err_nxt     = boot_err;

        case (state)
            ST_PWRUP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PWRUP_CYCLES - 1)) begin
                    state_nxt   = ST_MRST;
                    mem_rst_nxt = 1'b0;
                end
            end
            ST_MRST: begin
                cnt_nxt = cnt + CNT_W'(1);
                idx_nxt = '0;
                if (cnt == CNT_W'(MEMRST_CYCLES - 1)) begin
                    state_nxt = ST_CMD;
                    valid_nxt = 1'b1;
                    code_nxt  = seq_code('0);
                end
            end
            ST_CMD: begin
                // Valid is held until the controller accepts.
                if (mem_cmd_ready) begin
                    state_nxt = ST_WAIT;
                    valid_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                // Completion takes priority over a coincident timeout.
                if (mem_cmd_done) begin
                    state_nxt = ST_GAP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt   = ST_RETRY;
                    mem_rst_nxt = (retry < RTY_W'(MAX_RETRY));
                end
            end
            ST_GAP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(CMD_GAP - 1)) begin
                    if (idx == IDX_W'(SEQ_LEN - 1)) begin
                        state_nxt = ST_STAGE;
                        stage_nxt = rst_stage << 1;
                    end else begin
                        state_nxt = ST_CMD;
                        idx_nxt   = idx + IDX_W'(1);
                        valid_nxt = 1'b1;
                        code_nxt  = seq_code(idx + IDX_W'(1));
                    end
                end
            end
            ST_RETRY: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (retry >= RTY_W'(MAX_RETRY)) begin
                    // Still release the stages so the CPU can report the failure.
                    state_nxt = ST_STAGE;
                    err_nxt   = 1'b1;
                    stage_nxt = rst_stage << 1;
                end else if (cnt == CNT_W'(MEMRST_CYCLES - 1)) begin
                    state_nxt   = ST_MRST;
                    retry_nxt   = retry + RTY_W'(1);
                    mem_rst_nxt = 1'b0;
                end
            end
            ST_STAGE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (rst_stage == '0) begin
                    state_nxt = ST_DONE;
                    done_nxt  = ~boot_err;
                end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                    stage_nxt = rst_stage << 1;
                    cnt_nxt   = '0;
                end
            end
            ST_DONE: begin
                // Terminal until rst.
            end
            default: begin
                state_nxt = ST_PWRUP;
            end
        endcase

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_boot_seq.sv
// Self-checking bench for boot_seq with shortened timing parameters.
// A scoreboard queue holds expected accepted opcodes and rst_stage values,
// popped as the DUT accepts commands and releases stages.
module tb_boot_seq;

    localparam int unsigned PWRUP  = 20;
    localparam int unsigned MEMRST = 4;
    localparam int unsigned GAP    = 2;
    localparam int unsigned TMO    = 16;
    localparam int unsigned RETRY  = 2;
    localparam int unsigned N      = 3;
    localparam int unsigned STG    = 3;
    localparam int          BUDGET = 800;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_rst;
    logic         mem_cmd_valid;
    logic         mem_cmd_ready;
    logic [7:0]   mem_cmd_code;
    logic         mem_cmd_done;
    logic [N-1:0] rst_stage;
    logic         boot_done;
    logic         boot_err;

    always #5 clk = ~clk;

    boot_seq #(
        .PWRUP_CYCLES (PWRUP),
        .MEMRST_CYCLES(MEMRST),
        .CMD_GAP      (GAP),
        .TIMEOUT      (TMO),
        .MAX_RETRY    (RETRY),
        .N_STAGES     (N),
        .STAGE_GAP    (STG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rst      (mem_rst),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_code (mem_cmd_code),
        .mem_cmd_done (mem_cmd_done),
        .rst_stage    (rst_stage),
        .boot_done    (boot_done),
        .boot_err     (boot_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]   exp_codes[$];
    logic [N-1:0] exp_stage[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_mem_rst"},   32'(mem_rst),       32'd1);
        check({pfx, "_valid"},     32'(mem_cmd_valid), 32'd0);
        check({pfx, "_code"},      32'(mem_cmd_code),  32'h00);
        check({pfx, "_stage"},     32'(rst_stage),     32'h7);
        check({pfx, "_done"},      32'(boot_done),     32'd0);
        check({pfx, "_err"},       32'(boot_err),      32'd0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        mem_cmd_ready = 1'b1;
        mem_cmd_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    // drop_mask bit k: withhold done for the k-th accepted command.
    task automatic run_boot(input int drop_mask, input int dly, input int bp_cycles,
                            input bit mid_rst, input bit exp_err, input int exp_retries);
        int acc_n, dcnt, bp_left, cyc, hi_start, rises, last_stage_cyc;
        bit prev_valid, prev_ready, prev_mem_rst, mem_fall_seen, bp_on;
        bit rst_pending, rst_used, finished;
        logic [7:0]   prev_code;
        logic [N-1:0] prev_stage;

        acc_n = 0; dcnt = 0; bp_left = bp_cycles; cyc = 0; hi_start = -1;
        rises = 0; last_stage_cyc = -1;
        prev_valid = 0; prev_ready = 1; prev_mem_rst = 1; mem_fall_seen = 0;
        bp_on = 0; rst_pending = 0; rst_used = 0; finished = 0;
        prev_code = 8'h00; prev_stage = '1;

        exp_codes.delete();
        exp_stage.delete();
        if (mid_rst) begin
            exp_codes.push_back(8'h66);
            exp_codes.push_back(8'h99);
        end
        if (exp_err) begin
            for (int i = 0; i <= int'(RETRY); i++) exp_codes.push_back(8'h66);
        end else begin
            for (int i = 0; i <= exp_retries; i++) begin
                exp_codes.push_back(8'h66);
                exp_codes.push_back(8'h99);
                exp_codes.push_back(8'h35);
            end
        end
        exp_stage.push_back(3'b110);
        exp_stage.push_back(3'b100);
        exp_stage.push_back(3'b000);

        do_reset();

        for (int c = 0; c < BUDGET && !finished; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            mem_cmd_done = 1'b0;

            if (rst_pending) begin
                check_reset_values("midrst");
                rst          = 1'b0;
                mem_cmd_done = 1'b1;   // stray completion after the abort
                rst_pending  = 0;
                cyc = 0; dcnt = 0; hi_start = -1; mem_fall_seen = 0;
                prev_valid = 0; prev_ready = mem_cmd_ready; prev_mem_rst = 1;
                prev_stage = '1;
                continue;
            end

            if (prev_valid && prev_ready) begin
                if (exp_codes.size() == 0) check("extra_accept", 32'(prev_code), 32'h0);
                else check("cmd_code", 32'(prev_code), 32'(exp_codes.pop_front()));
                if (mid_rst && !rst_used && prev_code == 8'h99) begin
                    rst = 1'b1; rst_used = 1; rst_pending = 1;
                end else if (((drop_mask >> acc_n) & 1) == 0) begin
                    dcnt = dly;
                end
                acc_n++;
            end else if (prev_valid) begin
                check("valid_hold", 32'(mem_cmd_valid), 32'd1);
            end

            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) mem_cmd_done = 1'b1;
            end

            if (!mem_rst && !mem_fall_seen) begin
                check("mem_rst_fall", 32'(cyc), 32'(PWRUP));
                mem_fall_seen = 1;
            end
            if (!prev_mem_rst && mem_rst) begin
                rises++;
                hi_start = cyc;
            end
            if (prev_mem_rst && !mem_rst && hi_start >= 0) begin
                check("retry_rst_len", 32'(cyc - hi_start), 32'(MEMRST));
                hi_start = -1;
            end

            if (rst_stage != prev_stage) begin
                if (exp_stage.size() == 0) check("extra_stage", 32'(rst_stage), 32'hFFFF_FFFF);
                else check("stage_val", 32'(rst_stage), 32'(exp_stage.pop_front()));
                if (last_stage_cyc >= 0) check("stage_gap", 32'(cyc - last_stage_cyc), 32'(STG));
                last_stage_cyc = cyc;
            end
            if (boot_done && !finished) begin
                check("done_lat", 32'(cyc - last_stage_cyc), 32'd1);
                finished = 1;
            end
            if (boot_err && rst_stage == '0) finished = 1;

            if (bp_cycles > 0 && !bp_on && mem_cmd_valid && mem_cmd_code == 8'h99) bp_on = 1;
            if (bp_on && bp_left > 0) begin
                check("bp_valid", 32'(mem_cmd_valid), 32'd1);
                check("bp_code",  32'(mem_cmd_code),  32'h99);
                mem_cmd_ready = 1'b0;
                bp_left--;
            end else begin
                mem_cmd_ready = 1'b1;
            end

            prev_valid   = mem_cmd_valid;
            prev_ready   = mem_cmd_ready;
            prev_code    = mem_cmd_code;
            prev_mem_rst = mem_rst;
            prev_stage   = rst_stage;
        end

        check("finished", 32'(finished), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("final_done",    32'(boot_done),        32'(!exp_err));
        check("final_err",     32'(boot_err),         32'(exp_err));
        check("final_stage",   32'(rst_stage),        32'h0);
        check("final_mem_rst", 32'(mem_rst),          32'd0);
        check("final_valid",   32'(mem_cmd_valid),    32'd0);
        check("codes_left",    32'(exp_codes.size()), 32'd0);
        check("stages_left",   32'(exp_stage.size()), 32'd0);
        check("retry_count",   32'(rises),            32'(exp_retries));
    endtask

    initial begin
        rst           = 1'b1;
        mem_cmd_ready = 1'b1;
        mem_cmd_done  = 1'b0;

        // nominal
        run_boot(0, 3, 0, 0, 0, 0);
        // backpressure on 0x99 for 10 cycles
        run_boot(0, 3, 10, 0, 0, 0);
        // single timeout on the first 0x35
        run_boot(32'h4, 3, 0, 0, 0, 1);
        // done never arrives: retries exhausted
        run_boot(32'hFFFF, 3, 0, 0, 1, 2);
        // done on the final WAIT cycle wins over the timeout
        run_boot(0, int'(TMO), 0, 0, 0, 0);
        // reset while waiting on 0x99, stray done one cycle later
        run_boot(0, 3, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
